// File: rtl/ram_load_ctrl_pkg.sv
// ram_ctrl_pkg
//   Shared types and sizes for the RAM load controller slice.
//   RAM_ADDR_W / RAM_DATA_W : default RAM port widths
//   RAM_DEPTH               : words loaded per session (= 2**RAM_ADDR_W)
//   ram_ld_state_t          : load controller FSM states
package ram_ctrl_pkg;

  localparam int RAM_ADDR_W = 4;
  localparam int RAM_DATA_W = 8;
  localparam int RAM_DEPTH  = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_DONE
  } ram_ld_state_t;

endpackage

// File: rtl/ram_load_ctrl_if.sv
// ram_load_ctrl_if
//   Bundles every signal between the RAM load controller and its neighbours
//   (prog switch, byte loader, CPU bus/MAR, RAM write port, status).
//   slave modport  : the controller side
//   master modport : the environment side (switch, loader, CPU, RAM)
//   Signals: prog_mode, prog_abort, ld_valid, ld_data, ld_ready,
//            cpu_addr, cpu_wdata, cpu_we, ram_addr, ram_wdata, ram_we,
//            cpu_halt, busy, done, load_count[ADDR_W:0], cksum_err
interface ram_load_ctrl_if
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
);

  logic              prog_mode;
  logic              prog_abort;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic              cpu_halt;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   load_count;
  logic              cksum_err;

  modport slave (
    input  prog_mode, prog_abort, ld_valid, ld_data,
    input  cpu_addr, cpu_wdata, cpu_we,
    output ld_ready, ram_addr, ram_wdata, ram_we,
    output cpu_halt, busy, done, load_count, cksum_err
  );

  modport master (
    output prog_mode, prog_abort, ld_valid, ld_data,
    output cpu_addr, cpu_wdata, cpu_we,
    input  ld_ready, ram_addr, ram_wdata, ram_we,
    input  cpu_halt, busy, done, load_count, cksum_err
  );

endinterface

// File: rtl/ram_load_ctrl_edge_detector.sv
// edge_detector
//   Flags the cycle in which a level input first reads high.
//   clk           : system clock
//   rst           : asynchronous active-high reset
//   a_i           : level input
//   rising_edge_o : high while a_i is 1 and was 0 at the previous clock edge
module edge_detector (
  input  logic clk,
  input  logic rst,
  input  logic a_i,
  output logic rising_edge_o
);

  logic r_prev;

  // Remember last cycle's level; cleared to 0 so a level already high after
  // reset counts as a fresh edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_prev <= 1'b0;
    else     r_prev <= a_i;
  end

  assign rising_edge_o = a_i & ~r_prev;

endmodule

// File: rtl/ram_load_ctrl.sv
// ram_load_ctrl
//   Owns the single write port of the 16x8 program/data RAM. In idle the CPU
//   bus (MAR / bus write) passes straight through; a rising edge on prog_mode
//   opens a load session that halts the CPU, streams 16 loader bytes into
//   addresses 0..15 and then releases the CPU.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : ram_load_ctrl_if.slave (prog switch, loader handshake,
//              CPU bus in, RAM write port out, halt/busy/done/count/cksum)
//   Build option: define RAM_CKSUM_EN to append a checksum byte to every
//   session and drive cksum_err; otherwise cksum_err is tied low.
module ram_load_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic            clk,
  input  logic            rst,
  ram_load_ctrl_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  ram_ld_state_t     r_state;
  ram_ld_state_t     w_nextState;
  logic [ADDR_W-1:0] r_ptr;
  logic [CNT_W-1:0]  r_loadCount;
  logic              r_halt;
  logic              w_progEdge;
  logic              w_ldReady;
  logic              w_beat;
  logic              w_lastPtr;

  edge_detector u_edge (
    .clk           (clk),
    .rst           (rst),
    .a_i           (bus.prog_mode),
    .rising_edge_o (w_progEdge)
  );

  assign w_ldReady = (r_state == S_LOAD) || (r_state == S_CHECK);
  assign w_beat    = bus.ld_valid & w_ldReady;
  assign w_lastPtr = (r_ptr == ADDR_W'(DEPTH - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nextState;
  end

  // Next-state logic. Abort wins over everything in LOAD/CHECK; the beat
  // taken in the abort cycle is still written by the output mux below.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_progEdge) w_nextState = S_LOAD;
      end
      S_LOAD: begin
        if (bus.prog_abort) begin
          w_nextState = S_DONE;
        end else if (w_beat && w_lastPtr) begin
`ifdef RAM_CKSUM_EN
          w_nextState = S_CHECK;
`else
          w_nextState = S_DONE;
`endif
        end
      end
      S_CHECK: begin
        if (bus.prog_abort || w_beat) w_nextState = S_DONE;
      end
      S_DONE: begin
        w_nextState = S_IDLE;
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Write pointer and byte counter: cleared when a session opens, advanced
  // on each data beat. The pointer wraps after 15 so it never leaves the RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= '0;
      r_loadCount <= '0;
    end else if (r_state == S_IDLE && w_progEdge) begin
      r_ptr       <= '0;
      r_loadCount <= '0;
    end else if (r_state == S_LOAD && w_beat) begin
      r_ptr       <= r_ptr + 1'b1;
      r_loadCount <= r_loadCount + 1'b1;
    end
  end

  // CPU halt is registered from the next state so it rises in the first
  // LOAD cycle and falls in the cycle after DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_halt <= 1'b0;
    else     r_halt <= (w_nextState != S_IDLE);
  end

`ifdef RAM_CKSUM_EN
  logic [DATA_W-1:0] r_sum;
  logic [DATA_W-1:0] w_sumNext;
  logic              r_cksumErr;

  assign w_sumNext = r_sum + bus.ld_data;

  // Running modulo-256 sum of data beats; the trailing byte must bring it
  // to zero. An abort during CHECK leaves the error flag as it was.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum      <= '0;
      r_cksumErr <= 1'b0;
    end else if (r_state == S_IDLE && w_progEdge) begin
      r_sum      <= '0;
      r_cksumErr <= 1'b0;
    end else if (r_state == S_LOAD && w_beat) begin
      r_sum      <= w_sumNext;
    end else if (r_state == S_CHECK && w_beat && !bus.prog_abort) begin
      r_cksumErr <= (w_sumNext != '0);
    end
  end

  assign bus.cksum_err = r_cksumErr;
`else
  assign bus.cksum_err = 1'b0;
`endif

  // RAM port mux: CPU bus passes through with zero latency in idle, loader
  // owns the port otherwise. The write strobe is held off during reset so
  // the RAM is never disturbed while the block is being cleared.
  always_comb begin
    bus.ram_addr  = r_ptr;
    bus.ram_wdata = bus.ld_data;
    bus.ram_we    = 1'b0;
    if (r_state == S_IDLE) begin
      bus.ram_addr  = bus.cpu_addr;
      bus.ram_wdata = bus.cpu_wdata;
      bus.ram_we    = bus.cpu_we & ~rst;
    end else if (r_state == S_LOAD) begin
      bus.ram_we    = w_beat;
    end
  end

  assign bus.ld_ready   = w_ldReady;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.done       = (r_state == S_DONE);
  assign bus.cpu_halt   = r_halt;
  assign bus.load_count = r_loadCount;

endmodule

// File: tb/tb_ram_load_ctrl.sv
// tb_ram_load_ctrl
//   Directed bench for ram_load_ctrl: a behavioural 16x8 RAM hangs off the
//   write port and each scenario task drives the switch/loader/CPU inputs and
//   compares outputs and RAM contents against hand-computed values.
//   Checksum scenarios depend on RAM_CKSUM_EN.
module tb_ram_load_ctrl;
  import ram_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   testsRun    = 0;
  int   testsFailed = 0;

  ram_load_ctrl_if ifc ();

  ram_load_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  // The RAM this block feeds; pre-filled so untouched words are recognisable.
  logic [7:0] ram [16] = '{default: 8'hEE};

  always @(posedge clk) begin
    if (ifc.ram_we) ram[ifc.ram_addr] <= ifc.ram_wdata;
  end

  // Drive every input of the block in one go.
  task automatic applyStimulus(input logic mode, input logic abort, input logic valid,
                               input logic [7:0] data, input logic [3:0] cAddr,
                               input logic [7:0] cData, input logic cWe);
    ifc.prog_mode  = mode;
    ifc.prog_abort = abort;
    ifc.ld_valid   = valid;
    ifc.ld_data    = data;
    ifc.cpu_addr   = cAddr;
    ifc.cpu_wdata  = cData;
    ifc.cpu_we     = cWe;
  endtask

  // Back-to-back loader beats first, first+1, ... with prog_mode held high.
  task automatic runBeats(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 1'b1, first + 8'(i), 4'h0, 8'h00, 1'b0);
    end
  endtask

  task automatic test_reset;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    testsRun++;
    if ({ifc.busy, ifc.done, ifc.cpu_halt, ifc.ld_ready, ifc.ram_we, ifc.cksum_err} !== 6'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_flags: busy/done/halt/ready/we/err got %b expected 000000",
               {ifc.busy, ifc.done, ifc.cpu_halt, ifc.ld_ready, ifc.ram_we, ifc.cksum_err});
    end
    testsRun++;
    if (ifc.load_count !== 5'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_count: got %0d expected 0", ifc.load_count);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_passthrough;
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 4'h3, 8'hA5, 1'b1);
    #1;
    testsRun++;
    if ({ifc.ram_we, ifc.ram_addr, ifc.ram_wdata, ifc.ld_ready} !== {1'b1, 4'h3, 8'hA5, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL pass_write: we/addr/data/ready got %b/%h/%h/%b expected 1/3/a5/0",
               ifc.ram_we, ifc.ram_addr, ifc.ram_wdata, ifc.ld_ready);
    end
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 4'h9, 8'h3C, 1'b0);
    #1;
    testsRun++;
    if ({ifc.ram_we, ifc.ram_addr, ifc.ram_wdata} !== {1'b0, 4'h9, 8'h3C}) begin
      testsFailed++;
      $display("[TB] FAIL pass_idle: we/addr/data got %b/%h/%h expected 0/9/3c",
               ifc.ram_we, ifc.ram_addr, ifc.ram_wdata);
    end
    testsRun++;
    if (ram[3] !== 8'hA5 || ram[9] !== 8'hEE) begin
      testsFailed++;
      $display("[TB] FAIL pass_ram: ram[3]=%h ram[9]=%h expected a5 ee", ram[3], ram[9]);
    end
  endtask

  task automatic test_full_load;
    logic [7:0] expData;
    // Edge cycle: the CPU write still goes through.
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hFF, 4'h0, 8'h55, 1'b1);
    #1;
    testsRun++;
    if ({ifc.ram_we, ifc.ram_addr, ifc.ram_wdata, ifc.busy, ifc.ld_ready} !== {1'b1, 4'h0, 8'h55, 1'b0, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL full_edge_cpu: we/addr/data/busy/ready got %b/%h/%h/%b/%b expected 1/0/55/0/0",
               ifc.ram_we, ifc.ram_addr, ifc.ram_wdata, ifc.busy, ifc.ld_ready);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      expData = 8'h10 + 8'(i);
      applyStimulus(1'b1, 1'b0, 1'b1, expData, 4'h0, 8'h00, 1'b0);
      #1;
      testsRun++;
      if ({ifc.cpu_halt, ifc.ld_ready, ifc.busy, ifc.ram_we} !== 4'b1111 ||
          ifc.ram_addr !== 4'(i) || ifc.ram_wdata !== expData || ifc.load_count !== 5'(i)) begin
        testsFailed++;
        $display("[TB] FAIL full_beat%0d: halt/ready/busy/we=%b addr=%h data=%h count=%0d expected 1111 %h %h %0d",
                 i, {ifc.cpu_halt, ifc.ld_ready, ifc.busy, ifc.ram_we}, ifc.ram_addr, ifc.ram_wdata,
                 ifc.load_count, 4'(i), expData, i);
      end
    end
`ifdef RAM_CKSUM_EN
    // 0x10..0x1F sums to 0x78, so 0x88 closes it to zero.
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h88, 4'h0, 8'h00, 1'b0);
    #1;
    testsRun++;
    if ({ifc.ram_we, ifc.ld_ready} !== 2'b01 || ifc.load_count !== 5'd16) begin
      testsFailed++;
      $display("[TB] FAIL full_check: we/ready got %b%b count %0d expected 01 16",
               ifc.ram_we, ifc.ld_ready, ifc.load_count);
    end
`endif
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 1'b0);
    #1;
    testsRun++;
    if ({ifc.done, ifc.cpu_halt, ifc.busy, ifc.ld_ready, ifc.ram_we} !== 5'b11100 || ifc.load_count !== 5'd16) begin
      testsFailed++;
      $display("[TB] FAIL full_done: done/halt/busy/ready/we=%b count=%0d expected 11100 16",
               {ifc.done, ifc.cpu_halt, ifc.busy, ifc.ld_ready, ifc.ram_we}, ifc.load_count);
    end
    @(negedge clk);
    #1;
    testsRun++;
    if ({ifc.done, ifc.cpu_halt, ifc.busy, ifc.cksum_err} !== 4'b0000) begin
      testsFailed++;
      $display("[TB] FAIL full_release: done/halt/busy/err=%b expected 0000",
               {ifc.done, ifc.cpu_halt, ifc.busy, ifc.cksum_err});
    end
    // prog_mode still high: no new session may start.
    repeat (3) @(negedge clk);
    #1;
    testsRun++;
    if (ifc.busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL full_no_restart: busy got %b expected 0", ifc.busy);
    end
    for (int i = 0; i < 16; i++) begin
      testsRun++;
      if (ram[i] !== 8'h10 + 8'(i)) begin
        testsFailed++;
        $display("[TB] FAIL full_ram%0d: got %h expected %h", i, ram[i], 8'h10 + 8'(i));
      end
    end
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 1'b0);
  endtask

  task automatic test_gapped;
    int         beats;
    int         cyc;
    logic       v;
    logic [7:0] expData;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 1'b0);
    beats = 0;
    cyc   = 0;
    while (beats < 16 && cyc < 100) begin
      @(negedge clk);
      v       = (cyc % 3 == 0);
      expData = 8'h40 + 8'(beats);
      // CPU keeps toggling its write strobe at shifting addresses.
      applyStimulus(1'b1, 1'b0, v, expData, 4'(cyc), 8'hCC, cyc[0]);
      #1;
      testsRun++;
      if (ifc.ram_we !== v || (v && (ifc.ram_addr !== 4'(beats) || ifc.ram_wdata !== expData))) begin
        testsFailed++;
        $display("[TB] FAIL gap_cycle%0d: we=%b addr=%h data=%h expected we=%b addr=%h data=%h",
                 cyc, ifc.ram_we, ifc.ram_addr, ifc.ram_wdata, v, 4'(beats), expData);
      end
      if (v) beats++;
      cyc++;
    end
    testsRun++;
    if (beats != 16) begin
      testsFailed++;
      $display("[TB] FAIL gap_timeout: beats got %0d expected 16", beats);
    end
`ifdef RAM_CKSUM_EN
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 1'b0);
    #1;
    testsRun++;
    if ({ifc.ld_ready, ifc.done} !== 2'b10) begin
      testsFailed++;
      $display("[TB] FAIL gap_check_wait: ready/done got %b expected 10", {ifc.ld_ready, ifc.done});
    end
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h88, 4'h0, 8'h00, 1'b0);
`endif
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 1'b0);
    #1;
    testsRun++;
    if (ifc.done !== 1'b1 || ifc.load_count !== 5'd16) begin
      testsFailed++;
      $display("[TB] FAIL gap_done: done=%b count=%0d expected 1 16", ifc.done, ifc.load_count);
    end
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 1'b0);
    for (int i = 0; i < 16; i++) begin
      testsRun++;
      if (ram[i] !== 8'h40 + 8'(i)) begin
        testsFailed++;
        $display("[TB] FAIL gap_ram%0d: got %h expected %h", i, ram[i], 8'h40 + 8'(i));
      end
    end
  endtask

  task automatic test_abort;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 1'b0);
    runBeats(8'h60, 5);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 4'h0, 8'h00, 1'b0);
    #1;
    testsRun++;
    if (ifc.busy !== 1'b1 || ifc.done !== 1'b0 || ifc.load_count !== 5'd5) begin
      testsFailed++;
      $display("[TB] FAIL abort_req: busy=%b done=%b count=%0d expected 1 0 5",
               ifc.busy, ifc.done, ifc.load_count);
    end
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 1'b0);
    #1;
    testsRun++;
    if ({ifc.done, ifc.cpu_halt} !== 2'b11 || ifc.load_count !== 5'd5) begin
      testsFailed++;
      $display("[TB] FAIL abort_done: done/halt=%b count=%0d expected 11 5",
               {ifc.done, ifc.cpu_halt}, ifc.load_count);
    end
    @(negedge clk);
    #1;
    testsRun++;
    if ({ifc.done, ifc.cpu_halt, ifc.busy} !== 3'b000) begin
      testsFailed++;
      $display("[TB] FAIL abort_idle: done/halt/busy=%b expected 000", {ifc.done, ifc.cpu_halt, ifc.busy});
    end
    for (int i = 0; i < 16; i++) begin
      testsRun++;
      if (ram[i] !== ((i < 5) ? 8'h60 + 8'(i) : 8'h40 + 8'(i))) begin
        testsFailed++;
        $display("[TB] FAIL abort_ram%0d: got %h expected %h", i, ram[i],
                 (i < 5) ? 8'h60 + 8'(i) : 8'h40 + 8'(i));
      end
    end
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 1'b0);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 1'b0);
    runBeats(8'h70, 7);
    // Reset lands while a beat for address 7 is offered.
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h77, 4'h0, 8'h00, 1'b0);
    rst = 1'b1;
    #1;
    testsRun++;
    if ({ifc.busy, ifc.done, ifc.cpu_halt, ifc.ld_ready, ifc.ram_we} !== 5'b0 || ifc.load_count !== 5'd0) begin
      testsFailed++;
      $display("[TB] FAIL rstmid_outputs: busy/done/halt/ready/we=%b count=%0d expected 00000 0",
               {ifc.busy, ifc.done, ifc.cpu_halt, ifc.ld_ready, ifc.ram_we}, ifc.load_count);
    end
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    testsRun++;
    if ({ifc.busy, ifc.done} !== 2'b00) begin
      testsFailed++;
      $display("[TB] FAIL rstmid_no_done: busy/done=%b expected 00", {ifc.busy, ifc.done});
    end
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hA0, 4'h0, 8'h00, 1'b0);
    #1;
    testsRun++;
    if (ifc.ram_we !== 1'b1 || ifc.ram_addr !== 4'h0 || ifc.load_count !== 5'd0) begin
      testsFailed++;
      $display("[TB] FAIL rstmid_restart: we=%b addr=%h count=%0d expected 1 0 0",
               ifc.ram_we, ifc.ram_addr, ifc.load_count);
    end
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 4'h0, 8'h00, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 1'b0);
    #1;
    testsRun++;
    if (ifc.done !== 1'b1 || ifc.load_count !== 5'd1) begin
      testsFailed++;
      $display("[TB] FAIL rstmid_done: done=%b count=%0d expected 1 1", ifc.done, ifc.load_count);
    end
    @(negedge clk);
    testsRun++;
    if (ram[0] !== 8'hA0 || ram[1] !== 8'h71 || ram[6] !== 8'h76 || ram[7] !== 8'h47) begin
      testsFailed++;
      $display("[TB] FAIL rstmid_ram: ram0/1/6/7 got %h %h %h %h expected a0 71 76 47",
               ram[0], ram[1], ram[6], ram[7]);
    end
  endtask

  task automatic test_checksum;
`ifdef RAM_CKSUM_EN
    // Bytes 1..16 sum to 0x88; 0x78 completes a clean session.
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 1'b0);
    runBeats(8'h01, 16);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h78, 4'h0, 8'h00, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 1'b0);
    #1;
    testsRun++;
    if ({ifc.done, ifc.cksum_err} !== 2'b10) begin
      testsFailed++;
      $display("[TB] FAIL cksum_good: done/err=%b expected 10", {ifc.done, ifc.cksum_err});
    end
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 1'b0);
    // Same bytes with a zero trailer must flag an error.
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 1'b0);
    runBeats(8'h01, 16);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00, 4'h0, 8'h00, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 1'b0);
    #1;
    testsRun++;
    if ({ifc.done, ifc.cksum_err} !== 2'b11) begin
      testsFailed++;
      $display("[TB] FAIL cksum_bad: done/err=%b expected 11", {ifc.done, ifc.cksum_err});
    end
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 1'b0);
    #1;
    testsRun++;
    if ({ifc.busy, ifc.cksum_err} !== 2'b01) begin
      testsFailed++;
      $display("[TB] FAIL cksum_sticky: busy/err=%b expected 01", {ifc.busy, ifc.cksum_err});
    end
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 4'h0, 8'h00, 1'b0);
    #1;
    testsRun++;
    if ({ifc.busy, ifc.cksum_err} !== 2'b10) begin
      testsFailed++;
      $display("[TB] FAIL cksum_clear: busy/err=%b expected 10", {ifc.busy, ifc.cksum_err});
    end
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 1'b0);
    @(negedge clk);
`else
    // Without the checksum option the session ends after 16 data beats and
    // any further byte is not consumed.
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 1'b0);
    runBeats(8'h01, 16);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h78, 4'h0, 8'h00, 1'b0);
    #1;
    testsRun++;
    if ({ifc.done, ifc.ld_ready, ifc.ram_we, ifc.cksum_err} !== 4'b1000) begin
      testsFailed++;
      $display("[TB] FAIL nocksum_done: done/ready/we/err=%b expected 1000",
               {ifc.done, ifc.ld_ready, ifc.ram_we, ifc.cksum_err});
    end
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 1'b0);
    for (int i = 0; i < 16; i++) begin
      testsRun++;
      if (ram[i] !== 8'h01 + 8'(i)) begin
        testsFailed++;
        $display("[TB] FAIL nocksum_ram%0d: got %h expected %h", i, ram[i], 8'h01 + 8'(i));
      end
    end
`endif
  endtask

  initial begin
    test_reset;
    test_passthrough;
    test_full_load;
    test_gapped;
    test_abort;
    test_reset_mid;
    test_checksum;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
